// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the RV32I core.
// Holds one decoded instruction, resolves ALU operand sources and applies
// EX/MEM and MEM/WB forwarding. Operands are kept coherent while stalled.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_we,
    input  logic              in_a_sel,
    input  logic              in_b_sel,
    input  logic [3:0]        in_alu_sel,
    input  logic              fwd_m_we,
    input  logic [REG_AW-1:0] fwd_m_rd,
    input  logic [XLEN-1:0]   fwd_m_data,
    input  logic              fwd_w_we,
    input  logic [REG_AW-1:0] fwd_w_rd,
    input  logic [XLEN-1:0]   fwd_w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_select,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_we,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc
);

    // ALU select codes: {funct7[5], funct3}; immediate shifts share the codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    logic              valid_reg;
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   imm_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              we_reg;
    logic              a_sel_reg;
    logic              b_sel_reg;
    logic [3:0]        alu_sel_reg;

    logic              capture;
    logic              stall;
    logic              is_shift;
    logic [XLEN-1:0]   b_raw;

    // Per-operand views so both source paths share one generate body
    logic [REG_AW-1:0] src_addr [2];
    logic [XLEN-1:0]   src_data [2];
    logic [XLEN-1:0]   fwd_val  [2];

    assign src_addr[0] = in_rs1_addr;
    assign src_addr[1] = in_rs2_addr;
    assign src_data[0] = in_rs1_data;
    assign src_data[1] = in_rs2_data;

    assign in_ready = !valid_reg || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign stall    = valid_reg && !out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [REG_AW-1:0] addr_reg;
            logic [XLEN-1:0]   data_reg;
            logic              m_hit;
            logic              w_hit;
            logic              w_hit_in;

            assign m_hit    = fwd_m_we && (fwd_m_rd == addr_reg) && (addr_reg != '0);
            assign w_hit    = fwd_w_we && (fwd_w_rd == addr_reg) && (addr_reg != '0);
            assign w_hit_in = fwd_w_we && (fwd_w_rd == src_addr[gi]) && (src_addr[gi] != '0);

            // M bus is the younger producer, so it wins over W
            assign fwd_val[gi] = m_hit ? fwd_m_data : (w_hit ? fwd_w_data : data_reg);

            // Capture with same-cycle W bypass; refresh with forwarded value while stalled
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (capture) begin
                    addr_reg <= src_addr[gi];
                    if (w_hit_in)
                        data_reg <= fwd_w_data;
                    else if (src_addr[gi] == '0)
                        data_reg <= '0;
                    else
                        data_reg <= src_data[gi];
                end else if (!flush && stall) begin
                    data_reg <= fwd_val[gi];
                end
            end
        end
    endgenerate

    // Valid/handshake state and the non-operand instruction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            pc_reg      <= '0;
            imm_reg     <= '0;
            rd_reg      <= '0;
            we_reg      <= 1'b0;
            a_sel_reg   <= 1'b0;
            b_sel_reg   <= 1'b0;
            alu_sel_reg <= ALU_ADD;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg   <= 1'b1;
            pc_reg      <= in_pc;
            imm_reg     <= in_imm;
            rd_reg      <= in_rd_addr;
            we_reg      <= in_reg_we;
            a_sel_reg   <= in_a_sel;
            b_sel_reg   <= in_b_sel;
            alu_sel_reg <= in_alu_sel;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Operand muxing; shift amounts only use the low five bits of b
    always_comb begin
        is_shift = (alu_sel_reg == ALU_SLL) || (alu_sel_reg == ALU_SRL) ||
                   (alu_sel_reg == ALU_SRA);
        b_raw    = b_sel_reg ? imm_reg : fwd_val[1];
        alu_a    = a_sel_reg ? pc_reg : fwd_val[0];
        alu_b    = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
    end

    assign out_valid     = valid_reg;
    assign alu_select    = alu_sel_reg;
    assign ex_rd_addr    = rd_reg;
    assign ex_reg_we     = valid_reg && we_reg;
    assign ex_store_data = fwd_val[1];
    assign ex_pc         = pc_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the held instruction.
module tb_id_ex_stage;

    localparam logic [3:0] C_ADD = 4'b0000;
    localparam logic [3:0] C_SLL = 4'b0001;
    localparam logic [3:0] C_SRL = 4'b0101;
    localparam logic [3:0] C_SRA = 4'b1101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic        in_reg_we, in_a_sel, in_b_sel;
    logic [3:0]  in_alu_sel;
    logic        fwd_m_we, fwd_w_we;
    logic [4:0]  fwd_m_rd, fwd_w_rd;
    logic [31:0] fwd_m_data, fwd_w_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_select;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_rd_addr(in_rd_addr), .in_reg_we(in_reg_we),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_sel(in_alu_sel),
        .fwd_m_we(fwd_m_we), .fwd_m_rd(fwd_m_rd), .fwd_m_data(fwd_m_data),
        .fwd_w_we(fwd_w_we), .fwd_w_rd(fwd_w_rd), .fwd_w_data(fwd_w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rd_addr = 0;
        in_reg_we = 0; in_a_sel = 0; in_b_sel = 0; in_alu_sel = C_ADD;
        fwd_m_we = 0; fwd_m_rd = 0; fwd_m_data = 0;
        fwd_w_we = 0; fwd_w_rd = 0; fwd_w_data = 0; out_ready = 1;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [4:0] rd, input logic we, input logic as, input logic bs,
                           input logic [3:0] sel);
        in_valid = 1; in_pc = pc; in_rs1_addr = r1; in_rs2_addr = r2;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_rd_addr = rd;
        in_reg_we = we; in_a_sel = as; in_b_sel = bs; in_alu_sel = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (ex_reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %0b want 0", ex_reg_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (alu_select !== C_ADD) begin errors++; $display("FAIL reset_alu_select got %h want %h", alu_select, C_ADD); end
        checks++; if (ex_pc !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin errors++; $display("FAIL reset_fields got pc=%h a=%h b=%h want 0", ex_pc, alu_a, alu_b); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_add_stream();
        logic [31:0] d1, d2;
        for (int i = 0; i < 4; i++) begin
            d1 = (i == 0) ? 32'h5 : $urandom;
            d2 = (i == 0) ? 32'h3 : $urandom;
            present(32'h40 + 4 * i, 5'd1, 5'd2, d1, d2, 32'h0, 5'd4 + 5'(i), 1'b1, 1'b0, 1'b0, C_ADD);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || ex_reg_we !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got v=%0b we=%0b want 1/1", i, out_valid, ex_reg_we); end
            checks++; if (alu_a !== d1 || alu_b !== d2) begin errors++; $display("FAIL stream_ops[%0d] got a=%h b=%h want a=%h b=%h", i, alu_a, alu_b, d1, d2); end
            checks++; if (ex_rd_addr !== 5'd4 + 5'(i) || ex_pc !== 32'h40 + 4 * i) begin errors++; $display("FAIL stream_fields[%0d] got rd=%0d pc=%h", i, ex_rd_addr, ex_pc); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0 || ex_reg_we !== 1'b0) begin errors++; $display("FAIL stream_drain got v=%0b we=%0b want 0/0", out_valid, ex_reg_we); end
    endtask

    task automatic test_fwd_priority();
        present(32'h80, 5'd7, 5'd0, 32'h1111, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, C_ADD);
        tick();
        in_valid = 0; out_ready = 0;
        fwd_m_we = 1; fwd_m_rd = 7; fwd_m_data = 32'hAAAA;
        fwd_w_we = 1; fwd_w_rd = 7; fwd_w_data = 32'hBBBB;
        #1;
        checks++; if (alu_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_m_priority got %h want 0000aaaa", alu_a); end
        fwd_m_we = 0;
        #1;
        checks++; if (alu_a !== 32'hBBBB) begin errors++; $display("FAIL fwd_w_only got %h want 0000bbbb", alu_a); end
        idle_inputs();
        present(32'h84, 5'd0, 5'd0, 32'h5555, 32'h6666, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, C_ADD);
        tick();
        in_valid = 0; out_ready = 0;
        fwd_m_we = 1; fwd_m_rd = 0; fwd_m_data = 32'hAAAA;
        fwd_w_we = 1; fwd_w_rd = 0; fwd_w_data = 32'hBBBB;
        #1;
        checks++; if (alu_a !== 32'h0 || ex_store_data !== 32'h0) begin errors++; $display("FAIL fwd_x0 got a=%h st=%h want 0", alu_a, ex_store_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_capture_bypass();
        present(32'h90, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, C_ADD);
        fwd_w_we = 1; fwd_w_rd = 5; fwd_w_data = 32'h77;
        tick();
        idle_inputs();
        out_ready = 0;
        #1;
        checks++; if (alu_a !== 32'h77 || alu_b !== 32'h22) begin errors++; $display("FAIL capture_bypass got a=%h b=%h want 77/22", alu_a, alu_b); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_stall_refresh();
        present(32'hA0, 5'd1, 5'd3, 32'h1, 32'h9, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, C_ADD);
        tick();
        present(32'hA4, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, C_ADD);
        out_ready = 0;
        fwd_m_we = 1; fwd_m_rd = 3; fwd_m_data = 32'h1234;
        #1;
        checks++; if (in_ready !== 1'b0 || alu_b !== 32'h1234) begin errors++; $display("FAIL stall_fwd got rdy=%0b b=%h want 0/1234", in_ready, alu_b); end
        tick();
        fwd_m_we = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (alu_b !== 32'h1234 || ex_store_data !== 32'h1234) begin errors++; $display("FAIL stall_refresh[%0d] got b=%h st=%h want 1234", i, alu_b, ex_store_data); end
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || ex_pc !== 32'hA0) begin errors++; $display("FAIL stall_hold[%0d] got rdy=%0b v=%0b pc=%h want 0/1/a0", i, in_ready, out_valid, ex_pc); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_shift_auipc();
        present(32'hC0, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0FE3, 5'd5, 1'b1, 1'b0, 1'b1, C_SLL);
        tick();
        checks++; if (alu_b !== 32'h3 || alu_select !== C_SLL) begin errors++; $display("FAIL slli_b got b=%h sel=%h want 3/1", alu_b, alu_select); end
        present(32'h100, 5'd1, 5'd2, 32'h55, 32'h66, 32'h0000_1000, 5'd6, 1'b1, 1'b1, 1'b1, C_ADD);
        tick();
        checks++; if (alu_a !== 32'h100 || alu_b !== 32'h1000) begin errors++; $display("FAIL auipc got a=%h b=%h want 100/1000", alu_a, alu_b); end
        checks++; if (ex_store_data !== 32'h66) begin errors++; $display("FAIL store_data got %h want 66", ex_store_data); end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        present(32'h200, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, C_ADD);
        tick();
        present(32'h300, 5'd3, 5'd4, 32'h3, 32'h4, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, C_ADD);
        out_ready = 0; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || ex_reg_we !== 1'b0) begin errors++; $display("FAIL flush_valid got v=%0b we=%0b want 0/0", out_valid, ex_reg_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        checks++; if (ex_pc === 32'h300) begin errors++; $display("FAIL flush_dropped got pc=%h want not 300", ex_pc); end
        idle_inputs();
        tick();
    endtask

    // Model of the held instruction: the value a source register should show
    // is the newest producer on the result buses, else the captured value.
    logic        mv, mwe, mas, mbs;
    logic [31:0] mpc, mimm;
    logic [4:0]  mrd;
    logic [3:0]  msel;
    logic [4:0]  mreg [2];
    logic [31:0] mval [2];

    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held);
        if (r == 0) return 32'h0;
        if (fwd_m_we && fwd_m_rd == r) return fwd_m_data;
        if (fwd_w_we && fwd_w_rd == r) return fwd_w_data;
        return held;
    endfunction

    task automatic test_random();
        logic [31:0] op1, op2, ea, eb;
        logic        accept;
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        mv = 0; mwe = 0; mas = 0; mbs = 0; mpc = 0; mimm = 0; mrd = 0; msel = C_ADD;
        mreg[0] = 0; mreg[1] = 0; mval[0] = 0; mval[1] = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7); out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 9) == 0);
            in_pc = $urandom; in_imm = $urandom; in_rd_addr = 5'($urandom);
            in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
            in_rs1_data = $urandom; in_rs2_data = $urandom;
            in_reg_we = 1'($urandom); in_a_sel = 1'($urandom); in_b_sel = 1'($urandom);
            in_alu_sel = 4'($urandom);
            fwd_m_we = 1'($urandom); fwd_m_rd = 5'($urandom_range(0, 3)); fwd_m_data = $urandom;
            fwd_w_we = 1'($urandom); fwd_w_rd = 5'($urandom_range(0, 3)); fwd_w_data = $urandom;
            #1;
            op1 = newest(mreg[0], mval[0]);
            op2 = newest(mreg[1], mval[1]);
            ea = mas ? mpc : op1;
            eb = mbs ? mimm : op2;
            if (msel == C_SLL || msel == C_SRL || msel == C_SRA) eb = eb % 32;
            checks++; if (out_valid !== mv || in_ready !== (!mv || out_ready)) begin errors++; $display("FAIL rnd_hs[%0d] got v=%0b rdy=%0b want v=%0b", c, out_valid, in_ready, mv); end
            checks++; if (ex_reg_we !== (mv && mwe)) begin errors++; $display("FAIL rnd_we[%0d] got %0b want %0b", c, ex_reg_we, mv && mwe); end
            if (mv) begin
                checks++; if (alu_a !== ea || alu_b !== eb) begin errors++; $display("FAIL rnd_ops[%0d] got a=%h b=%h want a=%h b=%h", c, alu_a, alu_b, ea, eb); end
                checks++; if (ex_store_data !== op2 || ex_pc !== mpc || ex_rd_addr !== mrd || alu_select !== msel) begin errors++; $display("FAIL rnd_fields[%0d] got st=%h pc=%h rd=%0d sel=%h want st=%h pc=%h rd=%0d sel=%h", c, ex_store_data, ex_pc, ex_rd_addr, alu_select, op2, mpc, mrd, msel); end
            end
            accept = in_valid && (!mv || out_ready) && !flush;
            if (flush) begin
                mv = 0;
            end else if (accept) begin
                mv = 1; mpc = in_pc; mimm = in_imm; mrd = in_rd_addr; mwe = in_reg_we;
                mas = in_a_sel; mbs = in_b_sel; msel = in_alu_sel;
                mreg[0] = in_rs1_addr; mreg[1] = in_rs2_addr;
                mval[0] = (in_rs1_addr == 0) ? 32'h0 : ((fwd_w_we && fwd_w_rd == in_rs1_addr) ? fwd_w_data : in_rs1_data);
                mval[1] = (in_rs2_addr == 0) ? 32'h0 : ((fwd_w_we && fwd_w_rd == in_rs2_addr) ? fwd_w_data : in_rs2_data);
            end else if (mv && out_ready) begin
                mv = 0;
            end else if (mv) begin
                mval[0] = op1; mval[1] = op2;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        present(32'h400, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, C_ADD);
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b want 1", out_valid); end
        #1;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || ex_reg_we !== 1'b0) begin errors++; $display("FAIL areset_now got v=%0b we=%0b want 0/0", out_valid, ex_reg_we); end
        checks++; if (ex_pc !== 32'h0 || alu_select !== C_ADD) begin errors++; $display("FAIL areset_fields got pc=%h sel=%h want 0/0", ex_pc, alu_select); end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_add_stream();
        test_fwd_priority();
        test_capture_bypass();
        test_stall_refresh();
        test_shift_auipc();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the RV32I core. Sits directly upstream of the ALU and drives its a/b/select inputs.
- Latches one decoded instruction per handshake and resolves operand sources (register, PC, immediate).
- Applies EX/MEM and MEM/WB forwarding and keeps held operands coherent while stalled.
- Also carries rd, write-enable and store data to the downstream stage.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held/incoming instruction (branch taken)
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  instruction PC
in_rs1_addr / in_rs2_addr  in  REG_AW each  source register indices
in_rs1_data / in_rs2_data  in  XLEN each  register-file read data
in_imm  in  XLEN  sign-extended immediate
in_rd_addr  in  REG_AW  destination index
in_reg_we  in  1  instruction writes rd
in_a_sel  in  1  0=rs1, 1=PC
in_b_sel  in  1  0=rs2, 1=imm
in_alu_sel  in  4  ALU select code (defines.v encoding)
fwd_m_we, fwd_m_rd, fwd_m_data  in  1/REG_AW/XLEN  EX/MEM result bus
fwd_w_we, fwd_w_rd, fwd_w_data  in  1/REG_AW/XLEN  MEM/WB result bus
out_valid  out  1  held instruction valid
out_ready  in  1  execute/downstream accepts
alu_a, alu_b  out  XLEN each  ALU operands
alu_select  out  4  ALU select
ex_rd_addr  out  REG_AW  destination index
ex_reg_we  out  1  write-enable (0 when out_valid=0)
ex_store_data  out  XLEN  forwarded rs2 value
ex_pc  out  XLEN  held PC

Behaviour:
- Reset (rst_n low, async): out_valid=0; all held fields 0; alu_select=ALU_add code; ex_reg_we=0. in_ready is 1 after reset.
- in_ready = !out_valid || out_ready (combinational). Capture on in_valid && in_ready. Latency: 1 cycle from accept to out_valid.
- Transfer out occurs on out_valid && out_ready. If there is no new capture in the same cycle, out_valid clears next cycle. Back-to-back accept+transfer sustains 1 instr/cycle.
- flush (highest priority after reset): next cycle out_valid=0 and the same-cycle input is not captured. Held data may remain, but ex_reg_we must be 0.
- Forwarding, combinational on held rsN_addr:
  - if fwd_m_we && fwd_m_rd==rsN && rsN!=0, use fwd_m_data;
  - else if the same condition holds for the W bus, use fwd_w_data;
  - else use the held rsN data.
  - M has priority over W. Register 0 is never forwarded and always reads 0 (held x0 data forced to 0 on capture).
- Stall refresh: while out_valid && !out_ready, each cycle the forwarded rs1/rs2 values are written back into the held rs data. A producer that retires during the stall is therefore not lost.
- Capture-cycle bypass: on capture, if fwd_w_we && fwd_w_rd==in_rsN_addr && nonzero, latch fwd_w_data instead of in_rsN_data (covers a same-cycle register-file write).
- alu_a = a_sel ? pc : fwd rs1.
- alu_b = b_sel ? imm : fwd rs2. For shift selects (sll/srl/sra and the immediate forms) alu_b is zero-extended b[4:0]; upper bits are forced to 0.
- ex_store_data = forwarded rs2 regardless of b_sel.
- Outputs are held stable while stalled, apart from the forwarding-induced operand updates described above.

Test Plan:
- Reset mid-operation: out_valid=1 holding instr, assert rst_n=0 asynchronously -> out_valid=0, ex_reg_we=0 immediately, without waiting for a clock edge.
- ADD rs1=x1(0x5), rs2=x2(0x3), no hazards, out_ready=1 -> next cycle alu_a=5, alu_b=3, out_valid=1; a stream of 4 instrs sustains 1/cycle.
- Forward priority: rs1=x7, fwd_m (x7, 0xAAAA) and fwd_w (x7, 0xBBBB) both active -> alu_a=0xAAAA. Same case with rs1=x0 -> alu_a=0.
- Stall refresh: hold with out_ready=0, fwd_m x3=0x1234 for one cycle then deasserted, rs2=x3 -> alu_b remains 0x1234 after the bus drops; in_ready=0 throughout.
- SLLI with imm=0x0000_0FE3 -> alu_b=0x3. AUIPC-style a_sel=1, pc=0x100 -> alu_a=0x100.
- flush together with in_valid and out_ready=0 -> next cycle out_valid=0, ex_reg_we=0, incoming instr dropped, in_ready=1.
